cfg_pkt_loader: RTL

- Synthesizable, parametrised generator of the UM configuration packet stream.
- Brings the soft core up in three phases:
  - sets conf_sel=1;
  - streams a firmware image from an attached word memory as write-program packets, fragmented to a bounded packet length;
  - clears conf_sel=0.
- Sits in front of um_for_cpu data_in, muxed with the GMII path.
- Adds ready backpressure, multi-packet fragmentation, a programmable image length and a programmable inter-packet gap.

---
 rtl/cfg_pkt_loader.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cfg_pkt_loader.sv
// UM configuration packet generator: SEL=1, firmware write-program packets, SEL=0.
// Optional macro CFG_READBACK_EN adds a 9004 read-program pass plus a readback word counter.
module cfg_pkt_loader #(
    parameter int ADDR_W        = 16,
    parameter int WORDS_PER_PKT = 256,
    parameter int GAP_CYCLES    = 128,
    parameter int MAX_INSTR     = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] instr_num,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              pkt_out_valid,
    output logic [133:0]      pkt_out,
    input  logic              pkt_out_ready
`ifdef CFG_READBACK_EN
    ,
    input  logic              pkt_in_valid,
    input  logic [133:0]      pkt_in,
    output logic [ADDR_W-1:0] rb_words
`endif
);

    localparam logic [1:0]        TAG_HEAD = 2'b01;
    localparam logic [1:0]        TAG_BODY = 2'b00;
    localparam logic [1:0]        TAG_TAIL = 2'b10;
    localparam int                GW       = $clog2(GAP_CYCLES + 2);
    localparam logic [GW-1:0]     GAP_L    = GW'(GAP_CYCLES);
    localparam logic [ADDR_W:0]   WPP_L    = (ADDR_W + 1)'(WORDS_PER_PKT);
    localparam logic [ADDR_W:0]   ONE_L    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] MAX_L    = ADDR_W'(MAX_INSTR);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL1, S_GAP, S_PROG_BODY, S_RB_BODY, S_SEL0, S_DONE
    } state_t;

    typedef enum logic [1:0] {K_PROG, K_RB, K_SEL0} kind_t;

    function automatic logic [133:0] head_word(input logic [15:0] pkt_type);
        return {TAG_HEAD, 4'hf, 96'h1111_2222_3333_4444_5555_6666, pkt_type, 16'h0000};
    endfunction

    function automatic logic [133:0] sel_word(input logic [1:0] idx, input logic set);
        logic [133:0] w;
        w = {TAG_BODY, 4'hf, 128'h0};
        case (idx)
            2'd0:    w = head_word(16'h9001);
            2'd1:    w = {TAG_BODY, 4'hf, (set ? 128'h1_0000 : 128'h0)};
            2'd3:    w = {TAG_TAIL, 4'hf, 128'h0};
            default: w = {TAG_BODY, 4'hf, 128'h0};
        endcase
        return w;
    endfunction

    function automatic logic [133:0] body_word(input logic [31:0] instr,
                                               input logic [ADDR_W-1:0] addr,
                                               input logic last);
        return {(last ? TAG_TAIL : TAG_BODY), 4'hf, 48'h0, instr, 16'h0, 16'(addr), 16'h0};
    endfunction

    state_t              r_state, w_next_state;
    kind_t               r_next;
    logic [ADDR_W-1:0]   r_n;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [ADDR_W:0]     r_pkt_left;
    logic [GW-1:0]       r_gap_cnt;
    logic [1:0]          r_widx;
    logic                r_tail_sent;
    logic                r_valid;
    logic [133:0]        r_pkt;
    logic [ADDR_W-1:0]   r_rd_cnt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_inflight;
    logic [31:0]         r_fifo [2];
    logic                r_wptr, r_rptr;
    logic [1:0]          r_fifo_cnt;

    logic                w_adv, w_load, w_pop, w_last, w_more, w_rd, w_start;
    logic [133:0]        w_word;
    logic [1:0]          w_occ;
    logic [ADDR_W:0]     w_remain;

    assign w_adv    = !r_valid || pkt_out_ready;
    assign w_last   = (r_pkt_left == ONE_L);
    assign w_more   = ({1'b0, r_out_addr} + ONE_L) < {1'b0, r_n};
    assign w_remain = {1'b0, r_n} - {1'b0, r_out_addr};
    assign w_start  = (r_state == S_IDLE) && start;
    assign w_occ    = r_fifo_cnt + {1'b0, r_inflight};

    // Prefetch keeps at most two words in flight or buffered, so the skid FIFO never overflows.
    assign w_rd = (r_state != S_IDLE) && (r_state != S_DONE) && (r_rd_cnt < r_n) &&
                  ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

    assign mem_rd        = w_rd;
    assign mem_addr      = r_mem_addr;
    assign pkt_out_valid = r_valid;
    assign pkt_out       = r_pkt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:      if (start) w_next_state = S_SEL1;
            S_SEL1:      if (w_adv && r_widx == 2'd3) w_next_state = S_GAP;
            S_GAP: begin
                if (w_adv && r_gap_cnt == GAP_L) begin
                    unique case (r_next)
                        K_PROG:  w_next_state = S_PROG_BODY;
                        K_RB:    w_next_state = S_RB_BODY;
                        default: w_next_state = S_SEL0;
                    endcase
                end
            end
            S_PROG_BODY: if (w_adv && r_fifo_cnt != 2'd0 && w_last) w_next_state = S_GAP;
            S_RB_BODY:   if (w_adv && w_last) w_next_state = S_GAP;
            S_SEL0:      if (w_adv && r_tail_sent) w_next_state = S_DONE;
            S_DONE:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_pop  = 1'b0;
        w_word = '0;
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        unique case (r_state)
            S_SEL1: begin
                w_load = w_adv;
                w_word = sel_word(r_widx, 1'b1);
            end
            S_GAP: begin
                w_load = w_adv && (r_gap_cnt == GAP_L);
                unique case (r_next)
                    K_PROG:  w_word = head_word(16'h9003);
                    K_RB:    w_word = head_word(16'h9004);
                    default: w_word = head_word(16'h9001);
                endcase
            end
            S_PROG_BODY: begin
                w_load = w_adv && (r_fifo_cnt != 2'd0);
                w_pop  = w_load;
                w_word = body_word(r_fifo[r_rptr], r_out_addr, w_last);
            end
            S_RB_BODY: begin
                w_load = w_adv;
                w_word = body_word(32'h0, r_out_addr, w_last);
            end
            S_SEL0: begin
                w_load = w_adv && !r_tail_sent;
                w_word = sel_word(r_widx, 1'b0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pkt       <= '0;
            r_next      <= K_SEL0;
            r_n         <= '0;
            r_out_addr  <= '0;
            r_pkt_left  <= '0;
            r_gap_cnt   <= '0;
            r_widx      <= '0;
            r_tail_sent <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_pkt   <= w_word;
            end else if (pkt_out_ready) begin
                r_valid <= 1'b0;
            end

            if (w_start) begin
                r_n         <= (instr_num > MAX_L) ? MAX_L : instr_num;
                r_out_addr  <= '0;
                r_widx      <= '0;
                r_tail_sent <= 1'b0;
            end

            unique case (r_state)
                S_SEL1: if (w_load) begin
                    r_widx <= r_widx + 2'd1;
                    if (r_widx == 2'd3) begin
                        r_gap_cnt <= '0;
                        r_next    <= (r_n != '0) ? K_PROG : K_SEL0;
                    end
                end
                S_GAP: begin
                    if (w_load) begin
                        r_pkt_left  <= (w_remain < WPP_L) ? w_remain : WPP_L;
                        r_widx      <= 2'd1;
                        r_tail_sent <= 1'b0;
                    end else if (w_adv && r_gap_cnt != GAP_L) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_PROG_BODY: if (w_load) begin
                    r_out_addr <= r_out_addr + 1'b1;
                    r_pkt_left <= r_pkt_left - ONE_L;
                    if (w_last) begin
                        r_gap_cnt <= '0;
                        if (w_more) begin
                            r_next <= K_PROG;
                        end else begin
`ifdef CFG_READBACK_EN
                            r_next     <= K_RB;
                            r_out_addr <= '0;
`else
                            r_next     <= K_SEL0;
`endif
                        end
                    end
                end
                S_RB_BODY: if (w_load) begin
                    r_out_addr <= r_out_addr + 1'b1;
                    r_pkt_left <= r_pkt_left - ONE_L;
                    if (w_last) begin
                        r_gap_cnt <= '0;
                        r_next    <= w_more ? K_RB : K_SEL0;
                    end
                end
                S_SEL0: if (w_load) begin
                    r_widx <= r_widx + 2'd1;
                    if (r_widx == 2'd3) r_tail_sent <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read side: one read per cycle at most; data returns one cycle later into the skid FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt   <= '0;
            r_mem_addr <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_fifo_cnt <= '0;
        end else begin
            r_inflight <= w_rd;
            if (w_start) begin
                r_rd_cnt   <= '0;
                r_mem_addr <= '0;
            end else if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (({1'b0, r_rd_cnt} + ONE_L) < {1'b0, r_n}) r_mem_addr <= r_mem_addr + 1'b1;
            end
            if (r_inflight) r_wptr <= ~r_wptr;
            if (w_pop)      r_rptr <= ~r_rptr;
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // NOTE: FIFO storage has no reset; the count guards it, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (r_inflight) r_fifo[r_wptr] <= mem_rdata;
    end

`ifdef CFG_READBACK_EN
    logic              r_rx_in_rb;
    logic [ADDR_W-1:0] r_rb_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_in_rb <= 1'b0;
            r_rb_words <= '0;
        end else if (w_start) begin
            r_rx_in_rb <= 1'b0;
            r_rb_words <= '0;
        end else if (pkt_in_valid) begin
            if (pkt_in[133:132] == TAG_HEAD) begin
                r_rx_in_rb <= (pkt_in[31:16] == 16'h9004);
            end else if (r_rx_in_rb) begin
                r_rb_words <= r_rb_words + 1'b1;
                if (pkt_in[133:132] == TAG_TAIL) r_rx_in_rb <= 1'b0;
            end
        end
    end

    assign rb_words = r_rb_words;
`endif

endmodule
